// File: rtl/pulse_train_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen_if
// Purpose  : Control/config/status bundle between a pulse-train master and
//            the pulse_train_gen block.
// Revision : 1.0
// ============================================================================
interface pulse_train_gen_if #(
  parameter int DATA_W = 14,
  parameter int LEN_W  = 16,
  parameter int REP_W  = 8
);

  logic                     trigger;
  logic                     abort;
  logic signed [DATA_W-1:0] cfg_amp;
  logic        [LEN_W-1:0]  cfg_high;
  logic        [LEN_W-1:0]  cfg_low;
  logic        [REP_W-1:0]  cfg_repeats;

  logic                     ena;
  logic                     busy;
  logic                     done;
  logic        [REP_W-1:0]  pulse_idx;
  logic signed [DATA_W-1:0] sigout;

  modport master (
    output trigger, abort, cfg_amp, cfg_high, cfg_low, cfg_repeats,
    input  ena, busy, done, pulse_idx, sigout
  );

  modport slave (
    input  trigger, abort, cfg_amp, cfg_high, cfg_low, cfg_repeats,
    output ena, busy, done, pulse_idx, sigout
  );

endinterface
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Purpose  : Emits cfg_repeats rectangular pulses (high phase at cfg_amp, then
//            a zero gap) on a signed sample bus; abort, retrigger, done strobe.
//            Define PULSE_BIPOLAR_EN to negate odd-indexed pulses.
// Revision : 1.0
// ============================================================================
module pulse_train_gen #(
  parameter int DATA_W = 14,
  parameter int LEN_W  = 16,
  parameter int REP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t                   r_state,    w_state;
  logic signed [DATA_W-1:0] r_amp,      w_amp;
  logic        [LEN_W-1:0]  r_high,     w_high;
  logic        [LEN_W-1:0]  r_low,      w_low;
  logic        [REP_W-1:0]  r_rep,      w_rep;
  logic        [LEN_W-1:0]  r_high_cnt, w_high_cnt;
  logic        [LEN_W-1:0]  r_low_cnt,  w_low_cnt;
  logic        [REP_W-1:0]  r_idx,      w_idx;
  logic signed [DATA_W-1:0] r_sigout,   w_sigout;
  logic                     r_ena,      w_ena;
  logic                     r_done,     w_done;
  logic                     r_busy;

  logic                     w_pulse_end;
  logic        [REP_W-1:0]  w_idx_inc;
  logic signed [DATA_W-1:0] w_next_level;
  logic                     w_cfg_valid;

  // r_idx never exceeds r_rep-1, so the increment cannot wrap.
  assign w_idx_inc   = r_idx + REP_W'(1);
  assign w_cfg_valid = (bus.cfg_repeats != '0) && (bus.cfg_high != '0);

`ifdef PULSE_BIPOLAR_EN
  localparam logic signed [DATA_W-1:0] c_most_neg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] c_most_pos = {1'b0, {(DATA_W-1){1'b1}}};

  // Negating the most negative code would overflow, so it clips to full scale.
  always_comb begin
    w_next_level = r_amp;
    if (w_idx_inc[0]) begin
      if (r_amp == c_most_neg) begin
        w_next_level = c_most_pos;
      end else begin
        w_next_level = -r_amp;
      end
    end
  end
`else
  assign w_next_level = r_amp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_amp      <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_rep      <= '0;
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
      r_idx      <= '0;
      r_sigout   <= '0;
      r_ena      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_amp      <= w_amp;
      r_high     <= w_high;
      r_low      <= w_low;
      r_rep      <= w_rep;
      r_high_cnt <= w_high_cnt;
      r_low_cnt  <= w_low_cnt;
      r_idx      <= w_idx;
      r_sigout   <= w_sigout;
      r_ena      <= w_ena;
      r_busy     <= ~w_ena;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_amp       = r_amp;
    w_high      = r_high;
    w_low       = r_low;
    w_rep       = r_rep;
    w_high_cnt  = r_high_cnt;
    w_low_cnt   = r_low_cnt;
    w_idx       = r_idx;
    w_sigout    = r_sigout;
    w_ena       = r_ena;
    w_done      = 1'b0;
    w_pulse_end = 1'b0;

    if (bus.abort) begin
      w_state    = S_IDLE;
      w_high_cnt = '0;
      w_low_cnt  = '0;
      w_idx      = '0;
      w_sigout   = '0;
      w_ena      = 1'b1;
    end else if (bus.trigger) begin
      // Trigger restarts from any state; an empty train completes at once.
      w_amp  = bus.cfg_amp;
      w_high = bus.cfg_high;
      w_low  = bus.cfg_low;
      w_rep  = bus.cfg_repeats;
      w_idx  = '0;
      w_low_cnt = '0;
      if (w_cfg_valid) begin
        w_state    = S_HIGH;
        w_high_cnt = bus.cfg_high;
        w_sigout   = bus.cfg_amp;
        w_ena      = 1'b0;
      end else begin
        w_state    = S_IDLE;
        w_high_cnt = '0;
        w_sigout   = '0;
        w_ena      = 1'b1;
        w_done     = 1'b1;
      end
    end else begin
      case (r_state)
        S_HIGH: begin
          if (r_high_cnt > LEN_W'(1)) begin
            w_high_cnt = r_high_cnt - LEN_W'(1);
          end else begin
            w_high_cnt = '0;
            if (r_low != '0) begin
              w_state   = S_LOW;
              w_low_cnt = r_low;
              w_sigout  = '0;
            end else begin
              w_pulse_end = 1'b1;
            end
          end
        end
        S_LOW: begin
          if (r_low_cnt > LEN_W'(1)) begin
            w_low_cnt = r_low_cnt - LEN_W'(1);
          end else begin
            w_low_cnt   = '0;
            w_pulse_end = 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase

      if (w_pulse_end) begin
        if (w_idx_inc == r_rep) begin
          w_state    = S_IDLE;
          w_idx      = '0;
          w_sigout   = '0;
          w_ena      = 1'b1;
          w_done     = 1'b1;
        end else begin
          w_state    = S_HIGH;
          w_idx      = w_idx_inc;
          w_high_cnt = r_high;
          w_sigout   = w_next_level;
        end
      end
    end
  end

  assign bus.ena       = r_ena;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pulse_idx = r_idx;
  assign bus.sigout    = r_sigout;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Purpose  : Self-checking bench for pulse_train_gen against an arithmetic
//            model of the pulse train (elapsed-cycle / period based).
// Revision : 1.0
// ============================================================================
module tb_pulse_train_gen;

  localparam int DATA_W = 14;
  localparam int LEN_W  = 16;
  localparam int REP_W  = 8;

  logic clk = 1'b0;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  pulse_train_gen_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  pulse_train_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a live train is described only by the cycles elapsed since its
  // first amplitude sample; everything else follows from the period.
  bit     m_active = 1'b0;
  bit     m_done   = 1'b0;
  longint m_k      = 0;
  int     m_amp    = 0;
  int     m_h      = 0;
  int     m_l      = 0;
  int     m_r      = 0;

  always begin : p_compare
    longint p, n, ph;
    longint exp_sig, exp_idx;
    bit     exp_ena;
    @(posedge clk);
    if (rst || bus.abort) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (bus.trigger) begin
      m_amp = int'($signed(bus.cfg_amp));
      m_h   = int'(bus.cfg_high);
      m_l   = int'(bus.cfg_low);
      m_r   = int'(bus.cfg_repeats);
      m_k   = 0;
      m_active = (m_r > 0) && (m_h > 0);
      m_done   = !m_active;
    end else if (m_active) begin
      m_k++;
      m_done = (m_k == longint'(m_r) * (m_h + m_l));
      if (m_done) m_active = 1'b0;
    end else begin
      m_done = 1'b0;
    end

    exp_sig = 0;
    exp_idx = 0;
    exp_ena = 1'b1;
    if (m_active) begin
      p  = m_h + m_l;
      n  = m_k / p;
      ph = m_k % p;
      exp_idx = n;
      exp_ena = 1'b0;
      if (ph < m_h) exp_sig = m_amp;
`ifdef PULSE_BIPOLAR_EN
      if (ph < m_h && (n % 2) == 1) exp_sig = (-m_amp > 8191) ? 8191 : -m_amp;
`endif
    end

    #1;
    check("sigout",    longint'($signed(bus.sigout)), exp_sig);
    check("pulse_idx", longint'(bus.pulse_idx), exp_idx);
    check("ena",       longint'(bus.ena), longint'(exp_ena));
    check("busy",      longint'(bus.busy), longint'(!exp_ena));
    check("done",      longint'(bus.done), longint'(m_done));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int amp, input int h, input int l, input int r);
    bus.cfg_amp     = DATA_W'(amp);
    bus.cfg_high    = LEN_W'(h);
    bus.cfg_low     = LEN_W'(l);
    bus.cfg_repeats = REP_W'(r);
  endtask

  // Returns at the negedge right after the first amplitude sample.
  task automatic start(input int amp, input int h, input int l, input int r);
    set_cfg(amp, h, l, r);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
    set_cfg(0, 0, 0, 0);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    check("idle_sigout", longint'($signed(bus.sigout)), 0);
    check("idle_ena",    longint'(bus.ena), 1);
    check("idle_busy",   longint'(bus.busy), 0);
    check("idle_done",   longint'(bus.done), 0);
    check("idle_idx",    longint'(bus.pulse_idx), 0);

    // Three 200/400 pulses; config churn mid-train must be ignored.
    start(4096, 200, 400, 3);
    check("t2_first_sig", longint'($signed(bus.sigout)), 4096);
    check("t2_first_ena", longint'(bus.ena), 0);
    set_cfg(-5, 3, 3, 9);
    cyc(199);
    check("t2_last_high", longint'($signed(bus.sigout)), 4096);
    cyc(1);
    check("t2_first_low", longint'($signed(bus.sigout)), 0);
    cyc(400);
    check("t2_p1_sig", longint'($signed(bus.sigout)), 4096);
    check("t2_p1_idx", longint'(bus.pulse_idx), 1);
    cyc(600);
    check("t2_p2_idx", longint'(bus.pulse_idx), 2);
    cyc(599);
    check("t2_pre_done", longint'(bus.done), 0);
    check("t2_pre_ena",  longint'(bus.ena), 0);
    cyc(1);
    check("t2_done", longint'(bus.done), 1);
    check("t2_done_ena", longint'(bus.ena), 1);
    cyc(1);
    check("t2_done_once", longint'(bus.done), 0);

    // Empty trains: repeats=0 then high=0.
    start(77, 5, 5, 0);
    check("t3_rep0_done", longint'(bus.done), 1);
    check("t3_rep0_sig",  longint'($signed(bus.sigout)), 0);
    cyc(1);
    check("t3_rep0_strobe", longint'(bus.done), 0);
    start(77, 0, 5, 2);
    check("t3_h0_done", longint'(bus.done), 1);
    check("t3_h0_ena",  longint'(bus.ena), 1);
    cyc(2);

    // Gapless train.
    start(1234, 5, 0, 4);
    cyc(19);
    check("t4_last_sig", longint'($signed(bus.sigout)), 1234);
    check("t4_last_idx", longint'(bus.pulse_idx), 3);
    cyc(1);
    check("t4_done", longint'(bus.done), 1);
    check("t4_sig0", longint'($signed(bus.sigout)), 0);
    cyc(3);

    // Abort during pulse 1 high.
    start(300, 10, 10, 3);
    cyc(25);
    check("t5_p1_idx", longint'(bus.pulse_idx), 1);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("t5_abort_sig",  longint'($signed(bus.sigout)), 0);
    check("t5_abort_ena",  longint'(bus.ena), 1);
    check("t5_abort_done", longint'(bus.done), 0);
    cyc(60);

    // Retrigger during pulse 1 high.
    start(300, 10, 10, 3);
    cyc(25);
    set_cfg(100, 7, 3, 1);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    check("t6_restart_sig", longint'($signed(bus.sigout)), 100);
    check("t6_restart_idx", longint'(bus.pulse_idx), 0);
    cyc(10);
    check("t6_done", longint'(bus.done), 1);
    cyc(3);

    // Maximum repeat count.
    start(-20, 1, 1, 255);
    cyc(508);
    check("t7_last_idx", longint'(bus.pulse_idx), 254);
    check("t7_last_sig", longint'($signed(bus.sigout)), -20);
    cyc(2);
    check("t7_done", longint'(bus.done), 1);
    cyc(3);

    // Most negative amplitude, then reset during the low gap.
    start(-8192, 3, 2, 2);
    check("t8_p0_sig", longint'($signed(bus.sigout)), -8192);
    cyc(5);
`ifdef PULSE_BIPOLAR_EN
    check("t8_p1_sig", longint'($signed(bus.sigout)), 8191);
`else
    check("t8_p1_sig", longint'($signed(bus.sigout)), -8192);
`endif
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t8_rst_sig",  longint'($signed(bus.sigout)), 0);
    check("t8_rst_ena",  longint'(bus.ena), 1);
    check("t8_rst_busy", longint'(bus.busy), 0);
    check("t8_rst_idx",  longint'(bus.pulse_idx), 0);

    // Random traffic: short trains, frequent cfg churn, rare abort/reset.
    for (int i = 0; i < 4000; i++) begin
      bus.cfg_amp     = DATA_W'($urandom);
      bus.cfg_high    = LEN_W'($urandom_range(0, 6));
      bus.cfg_low     = LEN_W'($urandom_range(0, 5));
      bus.cfg_repeats = REP_W'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 255)
                                                            : $urandom_range(0, 4));
      bus.trigger = ($urandom_range(0, 24) == 0);
      bus.abort   = ($urandom_range(0, 149) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
    rst         = 1'b0;
    cyc(300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
